// File: rtl/axis_uart_tx.sv
// AXI-Stream to UART serializer: one AXIS word per frame, shifted out LSB-first
// with optional parity and 1-2 stop bits, paced by a single-cycle baud strobe.
`timescale 1ns/1ps

module axis_uart_tx #(
  parameter int unsigned PARITY_ENA  = 0,
  parameter int unsigned PARITY_TYPE = 0,
  parameter int unsigned STOP_BITS   = 1,
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned BUS_WIDTH   = 1
) (
  input  logic                   aclk,
  input  logic                   arst,
  input  logic [BUS_WIDTH*8-1:0] s_axis_tdata,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  input  logic                   uart_ena,
  output logic                   txd
);

  localparam int unsigned TDATA_W = BUS_WIDTH * 8;
  localparam int unsigned CNT_W   = 3;
  localparam int unsigned STOP_W  = 2;

  localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(DATA_BITS - 1);
  localparam logic [STOP_W-1:0] LAST_STOP = STOP_W'(STOP_BITS);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  state_t              state;
  logic [TDATA_W-1:0]  shreg;
  logic                parity_bit;
  logic [CNT_W-1:0]    bit_cnt;
  logic [STOP_W-1:0]   stop_cnt;

  logic data_xor_c;
  logic parity_c;

  // Parity of the word being accepted, captured alongside the data.
  assign data_xor_c = ^s_axis_tdata[DATA_BITS-1:0];

  always_comb begin
    parity_c = 1'b0;
    case (PARITY_TYPE)
      0:       parity_c = data_xor_c;
      1:       parity_c = ~data_xor_c;
      2:       parity_c = 1'b1;
      default: parity_c = 1'b0;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (arst) begin
      state         <= ST_IDLE;
      txd           <= 1'b1;
      s_axis_tready <= 1'b0;
      shreg         <= '0;
      parity_bit    <= 1'b0;
      bit_cnt       <= '0;
      stop_cnt      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          txd <= 1'b1;
          if (s_axis_tvalid && s_axis_tready) begin
            shreg         <= s_axis_tdata;
            parity_bit    <= parity_c;
            bit_cnt       <= '0;
            stop_cnt      <= '0;
            s_axis_tready <= 1'b0;
            state         <= ST_START;
          end else begin
            s_axis_tready <= 1'b1;
          end
        end

        // The strobe coinciding with acceptance never reaches this state.
        ST_START: begin
          if (uart_ena) begin
            txd   <= 1'b0;
            state <= ST_DATA;
          end
        end

        ST_DATA: begin
          if (uart_ena) begin
            txd   <= shreg[0];
            shreg <= shreg >> 1;
            if (bit_cnt == LAST_BIT) begin
              state <= (PARITY_ENA != 0) ? ST_PARITY : ST_STOP;
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
        end

        ST_PARITY: begin
          if (uart_ena) begin
            txd   <= parity_bit;
            state <= ST_STOP;
          end
        end

        // First strobe opens the stop period; the (STOP_BITS+1)-th closes it.
        ST_STOP: begin
          if (uart_ena) begin
            txd <= 1'b1;
            if (stop_cnt == LAST_STOP) begin
              stop_cnt      <= '0;
              s_axis_tready <= 1'b1;
              state         <= ST_IDLE;
            end else begin
              stop_cnt <= stop_cnt + STOP_W'(1);
            end
          end
        end

        default: begin
          txd   <= 1'b1;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axis_uart_tx.sv
// Bench for axis_uart_tx: six frame formats side by side, fixed vectors,
// corner sequences and random words checked against a frame-building model.
`timescale 1ns/1ps

module tb_axis_uart_tx;

  localparam int NCFG = 6;
  // Formats: 8N1, 8E1, 8O1, 7N2, 8M1, 8S1
  localparam int CFG_PE [NCFG] = '{0, 1, 1, 0, 1, 1};
  localparam int CFG_PT [NCFG] = '{0, 0, 1, 0, 2, 3};
  localparam int CFG_SB [NCFG] = '{1, 1, 1, 2, 1, 1};
  localparam int CFG_DB [NCFG] = '{8, 8, 8, 7, 8, 8};

  logic            tb_data_clk;
  logic            arst;
  logic            uart_ena;
  logic [NCFG-1:0] tvalid_v;
  logic [NCFG-1:0] tready_v;
  logic [NCFG-1:0] txd_v;
  logic [7:0]      tdata_v [NCFG];

  int scnt;
  int checks = 0;
  int passed = 0;

  typedef struct {
    int          cfg;
    logic [7:0]  data;
    logic [11:0] exp;
    int          n;
    string       nm;
  } vec_t;

  vec_t vecs [6];

  for (genvar g = 0; g < NCFG; g++) begin : g_dut
    axis_uart_tx #(
      .PARITY_ENA (CFG_PE[g]),
      .PARITY_TYPE(CFG_PT[g]),
      .STOP_BITS  (CFG_SB[g]),
      .DATA_BITS  (CFG_DB[g]),
      .BUS_WIDTH  (1)
    ) u_dut (
      .aclk         (tb_data_clk),
      .arst         (arst),
      .s_axis_tdata (tdata_v[g]),
      .s_axis_tvalid(tvalid_v[g]),
      .s_axis_tready(tready_v[g]),
      .uart_ena     (uart_ena),
      .txd          (txd_v[g])
    );
  end

  initial tb_data_clk = 1'b0;
  always #50 tb_data_clk = ~tb_data_clk;

  // Baud strobe: one cycle high every 10 clocks, changed on the falling edge.
  initial begin
    uart_ena = 1'b0;
    scnt = 0;
    forever begin
      @(negedge tb_data_clk);
      scnt = (scnt == 9) ? 0 : scnt + 1;
      uart_ena = (scnt == 0);
    end
  end

  initial begin
    #(100 * 60000);
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic chk_bit(input string nm, input logic got, input logic exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %b expected %b", nm, got, exp);
  endtask

  task automatic chk_int(input string nm, input int got, input int exp);
    checks++;
    if (got == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", nm, got, exp);
  endtask

  // Transmitted bit sequence for a word, built from the frame rules.
  function automatic void model_frame(input int c, input logic [7:0] d,
                                      output logic [11:0] exp, output int n);
    bit q[$];
    int ones = 0;
    q.push_back(1'b0);
    for (int b = 0; b < CFG_DB[c]; b++) begin
      q.push_back(d[b]);
      ones += int'(d[b]);
    end
    if (CFG_PE[c] != 0) begin
      case (CFG_PT[c])
        0:       q.push_back(ones % 2 == 1);
        1:       q.push_back(ones % 2 == 0);
        2:       q.push_back(1'b1);
        default: q.push_back(1'b0);
      endcase
    end
    for (int s = 0; s < CFG_SB[c]; s++) q.push_back(1'b1);
    exp = '0;
    foreach (q[j]) exp[j] = q[j];
    n = q.size();
  endfunction

  // Present a word and return just after the accepting edge.
  task automatic send(input int i, input logic [7:0] d, input bit align, output bit ok);
    int guard = 0;
    @(negedge tb_data_clk); #1;
    while (guard < 200 && !(tready_v[i] && (!align || uart_ena))) begin
      @(negedge tb_data_clk); #1;
      guard++;
    end
    ok = (guard < 200);
    if (!ok) begin
      chk_bit($sformatf("send%0d tready", i), tready_v[i], 1'b1);
      return;
    end
    tdata_v[i]  = d;
    tvalid_v[i] = 1'b1;
    @(posedge tb_data_clk); #1;
    tvalid_v[i] = 1'b0;
    tdata_v[i]  = 8'($urandom);
  endtask

  // Follow a frame strobe by strobe from just after acceptance to its end strobe.
  task automatic check_frame(input int i, input logic [11:0] exp, input int n, input string nm);
    int  k = -1;
    int  idle = 0;
    bit  hold_ok = 1'b1;
    bit  busy_ok = 1'b1;
    bit  stepped;
    logic want;
    while (k < n && idle < 40) begin
      @(posedge tb_data_clk);
      stepped = uart_ena;
      if (stepped) begin
        k++;
        idle = 0;
      end else begin
        idle++;
      end
      @(negedge tb_data_clk);
      want = (k < 0 || k >= n) ? 1'b1 : exp[k];
      if (stepped && k < n) chk_bit($sformatf("%s bit%0d", nm, k), txd_v[i], want);
      else if (txd_v[i] !== want) hold_ok = 1'b0;
      if (k < n && tready_v[i] !== 1'b0) busy_ok = 1'b0;
    end
    chk_int({nm, " strobes"}, k, n);
    chk_bit({nm, " ready_after"}, tready_v[i], 1'b1);
    chk_bit({nm, " txd_hold"}, hold_ok, 1'b1);
    chk_bit({nm, " ready_low_busy"}, busy_ok, 1'b1);
  endtask

  initial begin
    bit          ok;
    logic [11:0] e;
    logic [11:0] e2;
    int          n;
    int          n2;
    int          k;
    int          guard;
    bit          idle_ok;
    logic [7:0]  d;

    arst = 1'b1;
    tvalid_v = '0;
    for (int i = 0; i < NCFG; i++) tdata_v[i] = 8'h00;

    vecs[0] = '{0, 8'hA5, 12'h34A, 10, "8N1_A5"};
    vecs[1] = '{1, 8'hA5, 12'h54A, 11, "8E1_A5"};
    vecs[2] = '{2, 8'hA5, 12'h74A, 11, "8O1_A5"};
    vecs[3] = '{3, 8'hD5, 12'h3AA, 10, "7N2_D5"};
    vecs[4] = '{4, 8'h01, 12'h602, 11, "8M1_01"};
    vecs[5] = '{5, 8'h01, 12'h402, 11, "8S1_01"};

    repeat (3) @(negedge tb_data_clk);
    for (int i = 0; i < NCFG; i++) begin
      chk_bit($sformatf("reset txd%0d", i), txd_v[i], 1'b1);
      chk_bit($sformatf("reset ready%0d", i), tready_v[i], 1'b0);
    end
    arst = 1'b0;
    @(negedge tb_data_clk);
    for (int i = 0; i < NCFG; i++)
      chk_bit($sformatf("release ready%0d", i), tready_v[i], 1'b1);

    foreach (vecs[v]) begin
      send(vecs[v].cfg, vecs[v].data, 1'b0, ok);
      if (ok) check_frame(vecs[v].cfg, vecs[v].exp, vecs[v].n, vecs[v].nm);
    end

    // Acceptance on a strobe edge: that strobe must not start the frame.
    model_frame(0, 8'h5A, e, n);
    send(0, 8'h5A, 1'b1, ok);
    if (ok) check_frame(0, e, n, "aligned_5A");

    // Back-to-back with tvalid held: 0x00 then 0xFF on the cycle after the end strobe.
    model_frame(0, 8'h00, e, n);
    model_frame(0, 8'hFF, e2, n2);
    guard = 0;
    @(negedge tb_data_clk); #1;
    while (!tready_v[0] && guard < 200) begin
      @(negedge tb_data_clk); #1;
      guard++;
    end
    tdata_v[0]  = 8'h00;
    tvalid_v[0] = 1'b1;
    @(posedge tb_data_clk); #1;
    tdata_v[0] = 8'hFF;
    check_frame(0, e, n, "b2b_00");
    @(posedge tb_data_clk); #1;
    tvalid_v[0] = 1'b0;
    tdata_v[0]  = 8'h00;
    check_frame(0, e2, n2, "b2b_FF");
    idle_ok = 1'b1;
    repeat (30) begin
      @(negedge tb_data_clk);
      if (txd_v[0] !== 1'b1 || tready_v[0] !== 1'b1) idle_ok = 1'b0;
    end
    chk_bit("b2b no_extra_frame", idle_ok, 1'b1);

    // Reset during data bit 3 (strobe index 4), then a clean 0x3C frame.
    send(0, 8'hA5, 1'b0, ok);
    k = -1;
    guard = 0;
    while (k < 4 && guard < 100) begin
      @(posedge tb_data_clk);
      if (uart_ena) k++;
      guard++;
      @(negedge tb_data_clk);
    end
    chk_int("rst reach_bit3", k, 4);
    chk_bit("rst bit3_txd", txd_v[0], 1'b0);
    arst = 1'b1;
    @(negedge tb_data_clk);
    chk_bit("rst txd_high", txd_v[0], 1'b1);
    chk_bit("rst ready_low", tready_v[0], 1'b0);
    @(negedge tb_data_clk);
    chk_bit("rst ready_low_hold", tready_v[0], 1'b0);
    arst = 1'b0;
    @(negedge tb_data_clk);
    chk_bit("rst ready_release", tready_v[0], 1'b1);
    model_frame(0, 8'h3C, e, n);
    send(0, 8'h3C, 1'b0, ok);
    if (ok) check_frame(0, e, n, "post_rst_3C");

    // Random words on every format, with random idle gaps and strobe alignment.
    for (int c = 0; c < NCFG; c++) begin
      for (int r = 0; r < 6; r++) begin
        repeat ($urandom_range(0, 12)) @(negedge tb_data_clk);
        d = 8'($urandom);
        model_frame(c, d, e, n);
        send(c, d, ($urandom_range(0, 3) == 0), ok);
        if (ok) check_frame(c, e, n, $sformatf("rand_c%0d_%02h", c, d));
      end
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
